// File: rtl/pwm_capture_pkg.sv
// pwm_capture_pkg -- shared definitions for the PWM capture block.
//   state_t           : capture state machine encoding (SYNC, RUN)
//   DEF_FRAME_LEN     : default clock cycles per measurement frame
//   DEF_SAMPLE_W      : default width of the recovered sample
//   SYNC_STAGES       : depth of the Pulse_In synchronizer
//   is_pow2()         : selects shift-based scaling when FRAME_LEN allows it
package pwm_capture_pkg;

  typedef enum logic {
    SYNC = 1'b0,  // waiting for the first (partial) frame to close
    RUN  = 1'b1   // every frame wrap produces a sample
  } state_t;

  localparam int DEF_FRAME_LEN = 256;
  localparam int DEF_SAMPLE_W  = 8;
  localparam int SYNC_STAGES   = 2;

  function automatic bit is_pow2(input int value);
    return (value > 0) && ((value & (value - 1)) == 0);
  endfunction

endpackage

// File: rtl/pulse_sync.sv
// pulse_sync -- multi-flop synchronizer bringing the asynchronous PWM stream
// into the sysclk domain.
// Ports:
//   sysclk : clock, rising edge
//   reset  : synchronous, active-high; clears every stage
//   din    : asynchronous input
//   dout   : synchronized output (STAGES cycles of latency)
module pulse_sync
  import pwm_capture_pkg::*;
#(
  parameter int STAGES = SYNC_STAGES
) (
  input  logic sysclk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  logic [STAGES-1:0] stage_q;

  // NOTE: sequential state always uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbour, which is what makes this a
  // shift chain rather than a single flop.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      stage_q <= '0;
    end else begin
      stage_q <= {stage_q[STAGES-2:0], din};
    end
  end

  assign dout = stage_q[STAGES-1];

endmodule

// File: rtl/pwm_capture.sv
// pwm_capture -- recovers a duty-cycle value from a PWM/PDM stream by counting
// high cycles over fixed-length frames and scaling the count to SAMPLE_W bits.
// Ports:
//   sysclk       : clock, rising edge
//   reset        : synchronous, active-high; dominates every other event
//   Pulse_In     : asynchronous PWM/PDM input
//   Sample       : recovered duty-cycle value
//   Sample_Valid : Sample holds an unconsumed value
//   Sample_Ready : consumer takes Sample when high together with Sample_Valid
//   Overrun      : sticky, an unconsumed sample was overwritten
//   Locked       : high once the first complete frame has been measured
// Build option: define PWM_CAPTURE_AVG_EN to output a 4-tap moving average of
// the per-frame values instead of the single-frame value.
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int FRAME_LEN = DEF_FRAME_LEN,
  parameter int SAMPLE_W  = DEF_SAMPLE_W
) (
  input  logic                sysclk,
  input  logic                reset,
  input  logic                Pulse_In,
  output logic [SAMPLE_W-1:0] Sample,
  output logic                Sample_Valid,
  input  logic                Sample_Ready,
  output logic                Overrun,
  output logic                Locked
);

  localparam int CNT_W   = $clog2(FRAME_LEN);
  localparam int HIGH_W  = $clog2(FRAME_LEN + 1);  // must hold FRAME_LEN itself
  localparam int SCALE_W = HIGH_W + SAMPLE_W;
  localparam int LOG2_FL = $clog2(FRAME_LEN);
  localparam bit IS_POW2 = is_pow2(FRAME_LEN);

  localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(FRAME_LEN - 1);
  localparam logic [SCALE_W-1:0] SAT_MAX  = {{HIGH_W{1'b0}}, {SAMPLE_W{1'b1}}};

  logic                pulse_s;
  logic [CNT_W-1:0]    frame_cnt;
  logic [HIGH_W-1:0]   high_cnt;
  logic                wrap;
  logic                load;
  state_t              state;
  logic [HIGH_W-1:0]   closing_cnt;
  logic [SCALE_W-1:0]  scaled_full;
  logic [SCALE_W-1:0]  scaled_raw;
  logic [SAMPLE_W-1:0] frame_val;
  logic [SAMPLE_W-1:0] next_sample;

  pulse_sync #(
    .STAGES(SYNC_STAGES)
  ) u_pulse_sync (
    .sysclk (sysclk),
    .reset  (reset),
    .din    (Pulse_In),
    .dout   (pulse_s)
  );

  assign wrap = (frame_cnt == LAST_CNT);
  // Only frames that started after lock produce samples; the first wrap after
  // reset closes a frame whose start is undefined relative to the stream.
  assign load = wrap && (state == RUN);

  // Frame and high-cycle counters. The wrap cycle belongs to the closing frame,
  // so its synchronized input is folded into closing_cnt, not into high_cnt.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      frame_cnt <= '0;
      high_cnt  <= '0;
    end else if (wrap) begin
      frame_cnt <= '0;
      high_cnt  <= '0;
    end else begin
      frame_cnt <= frame_cnt + CNT_W'(1);
      high_cnt  <= high_cnt + HIGH_W'(pulse_s);
    end
  end

  assign closing_cnt = high_cnt + HIGH_W'(pulse_s);

  // Scale count * 2^SAMPLE_W / FRAME_LEN, then clamp: a fully-high frame maps
  // to 2^SAMPLE_W, one past the largest representable sample.
  // NOTE: every signal written in always_comb gets an unconditional value
  // first, so no path leaves it holding its old value and no latch is inferred.
  always_comb begin
    scaled_full = SCALE_W'(closing_cnt) << SAMPLE_W;
    scaled_raw  = scaled_full;
    if (IS_POW2) begin
      scaled_raw = scaled_full >> LOG2_FL;
    end else begin
      scaled_raw = scaled_full / SCALE_W'(FRAME_LEN);
    end
    frame_val = (scaled_raw > SAT_MAX) ? {SAMPLE_W{1'b1}} : scaled_raw[SAMPLE_W-1:0];
  end

  // Capture state machine; Locked is registered alongside the state.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state  <= SYNC;
      Locked <= 1'b0;
    end else begin
      case (state)
        SYNC: begin
          if (wrap) begin
            state  <= RUN;
            Locked <= 1'b1;
          end
        end
        RUN: begin
          state  <= RUN;
          Locked <= 1'b1;
        end
        default: begin
          state  <= SYNC;
          Locked <= 1'b0;
        end
      endcase
    end
  end

`ifdef PWM_CAPTURE_AVG_EN
  localparam int SUM_W = SAMPLE_W + 2;

  logic [SAMPLE_W-1:0] hist_0;
  logic [SAMPLE_W-1:0] hist_1;
  logic [SAMPLE_W-1:0] hist_2;
  logic [SUM_W-1:0]    avg_sum;

  // NOTE: the history is storage, yet it is reset on purpose: the average must
  // ramp up from zero after reset rather than mix in stale frames.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      hist_0 <= '0;
      hist_1 <= '0;
      hist_2 <= '0;
    end else if (load) begin
      hist_0 <= frame_val;
      hist_1 <= hist_0;
      hist_2 <= hist_1;
    end
  end

  assign avg_sum     = SUM_W'(frame_val) + SUM_W'(hist_0) + SUM_W'(hist_1) + SUM_W'(hist_2);
  assign next_sample = SAMPLE_W'(avg_sum >> 2);
`else
  assign next_sample = frame_val;
`endif

  // Output register with valid/ready handshake. A load in the same cycle as a
  // consume wins: the new value stays valid and it is not an overrun.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      Sample       <= '0;
      Sample_Valid <= 1'b0;
      Overrun      <= 1'b0;
    end else if (load) begin
      Sample       <= next_sample;
      Sample_Valid <= 1'b1;
      if (Sample_Valid && !Sample_Ready) begin
        Overrun <= 1'b1;
      end
    end else if (Sample_Valid && Sample_Ready) begin
      Sample_Valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture -- directed, self-checking bench for pwm_capture
// (FRAME_LEN=256, SAMPLE_W=8). Expected samples come from the stimulus mode:
// constant high -> 255, constant low -> 0, 25% PWM -> 64, passed through a
// small 4-tap history when PWM_CAPTURE_AVG_EN is defined.
module tb_pwm_capture;

  localparam int FL = 256;
  localparam int SW = 8;

  logic          clk;
  logic          reset;
  logic          pulse_in;
  logic [SW-1:0] sample;
  logic          sample_valid;
  logic          sample_ready;
  logic          overrun;
  logic          locked;

  int checks;
  int errors;
  int mode;    // 0: constant low, 1: constant high, 2: 25% PWM
  int phase;
  int since;   // cycles elapsed since the last frame wrap
  int h0, h1, h2;

  pwm_capture #(
    .FRAME_LEN(FL),
    .SAMPLE_W (SW)
  ) dut (
    .sysclk       (clk),
    .reset        (reset),
    .Pulse_In     (pulse_in),
    .Sample       (sample),
    .Sample_Valid (sample_valid),
    .Sample_Ready (sample_ready),
    .Overrun      (overrun),
    .Locked       (locked)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Stream generator: updates shortly after each falling edge so a mode change
  // made on a falling edge takes effect at the very next rising edge.
  initial begin
    pulse_in = 1'b0;
    phase    = 0;
    forever begin
      @(negedge clk);
      #1;
      phase = phase + 1;
      case (mode)
        1:       pulse_in = 1'b1;
        2:       pulse_in = ((phase % 256) < 64);
        default: pulse_in = 1'b0;
      endcase
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int model_push(input int s);
    int r;
`ifdef PWM_CAPTURE_AVG_EN
    r  = (s + h0 + h1 + h2) >> 2;
    h2 = h1;
    h1 = h0;
    h0 = s;
`else
    r = s;
`endif
    return r;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    h0 = 0; h1 = 0; h2 = 0;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    since = since + 1;
  endtask

  // Counts falling edges until Locked rises; the lock edge is a frame wrap.
  task automatic wait_locked(output int n);
    n = 0;
    while (locked !== 1'b1 && n < 2 * FL) begin
      @(negedge clk);
      n = n + 1;
    end
    since = 0;
  endtask

  // Advances to just after the next frame wrap. The mode is switched so the
  // synchronized input changes exactly at the start of the following frame.
  task automatic wait_load(input int next_mode);
    repeat (FL - 2 - since) @(posedge clk);
    @(negedge clk);
    mode = next_mode;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    since = 0;
  endtask

  task automatic test_reset();
    int n;
    mode = 1;
    sample_ready = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++; if (sample !== 8'd0) begin $display("FAIL reset_sample: got %0d want 0", sample); errors++; end
    checks++; if (sample_valid !== 1'b0) begin $display("FAIL reset_valid: got %b want 0", sample_valid); errors++; end
    checks++; if (overrun !== 1'b0) begin $display("FAIL reset_overrun: got %b want 0", overrun); errors++; end
    checks++; if (locked !== 1'b0) begin $display("FAIL reset_locked: got %b want 0", locked); errors++; end
    reset = 1'b0;
    h0 = 0; h1 = 0; h2 = 0;
    wait_locked(n);
    checks++; if (n !== FL) begin $display("FAIL reset_lock_time: got %0d cycles want %0d", n, FL); errors++; end
    checks++; if (sample_valid !== 1'b0) begin $display("FAIL reset_valid_at_lock: got %b want 0", sample_valid); errors++; end
  endtask

  task automatic test_const_high();
    int n;
    int exp;
    bit early;
    mode = 1;
    sample_ready = 1'b1;
    do_reset();
    wait_locked(n);
    early = 1'b0;
    repeat (FL - 3) begin
      step();
      if (sample_valid === 1'b1) early = 1'b1;
    end
    checks++; if (early !== 1'b0) begin $display("FAIL high_early_valid: valid seen before one frame after lock"); errors++; end
    for (int k = 0; k < 4; k++) begin
      wait_load(1);
      exp = model_push(255);
      checks++; if (sample_valid !== 1'b1) begin $display("FAIL high_valid[%0d]: got %b want 1", k, sample_valid); errors++; end
      checks++; if (sample !== exp[SW-1:0]) begin $display("FAIL high_sample[%0d]: got %0d want %0d", k, sample, exp); errors++; end
      step();
      checks++; if (sample_valid !== 1'b0) begin $display("FAIL high_consume[%0d]: got %b want 0", k, sample_valid); errors++; end
    end
  endtask

  task automatic test_const_low();
    int n;
    int exp;
    mode = 0;
    sample_ready = 1'b1;
    do_reset();
    wait_locked(n);
    checks++; if (locked !== 1'b1) begin $display("FAIL low_locked: got %b want 1", locked); errors++; end
    for (int k = 0; k < 3; k++) begin
      wait_load(0);
      exp = model_push(0);
      checks++; if (sample_valid !== 1'b1) begin $display("FAIL low_valid[%0d]: got %b want 1", k, sample_valid); errors++; end
      checks++; if (sample !== exp[SW-1:0]) begin $display("FAIL low_sample[%0d]: got %0d want %0d", k, sample, exp); errors++; end
    end
  endtask

  task automatic test_duty25();
    int n;
    int exp;
    int got;
    mode = 2;
    sample_ready = 1'b1;
    do_reset();
    wait_locked(n);
    for (int k = 0; k < 5; k++) begin
      wait_load(2);
      exp = model_push(64);
      got = int'(sample);
      checks++;
      if (got < exp - 1 || got > exp + 1) begin
        $display("FAIL duty25_sample[%0d]: got %0d want %0d +/-1", k, got, exp); errors++;
      end
    end
  endtask

  task automatic test_overrun();
    int n;
    int exp;
    mode = 1;
    sample_ready = 1'b1;
    do_reset();
    wait_locked(n);
    wait_load(1);
    exp = model_push(255);
    step();
    checks++; if (sample_valid !== 1'b0) begin $display("FAIL ovr_first_consume: got %b want 0", sample_valid); errors++; end
    sample_ready = 1'b0;
    wait_load(0);
    exp = model_push(255);
    checks++; if (sample !== exp[SW-1:0]) begin $display("FAIL ovr_first_sample: got %0d want %0d", sample, exp); errors++; end
    checks++; if (overrun !== 1'b0) begin $display("FAIL ovr_not_yet: got %b want 0", overrun); errors++; end
    repeat (3) step();
    checks++; if (sample !== exp[SW-1:0] || sample_valid !== 1'b1) begin
      $display("FAIL ovr_stable: got %0d/%b want %0d/1", sample, sample_valid, exp); errors++;
    end
    wait_load(1);
    exp = model_push(0);
    checks++; if (sample !== exp[SW-1:0]) begin $display("FAIL ovr_second_sample: got %0d want %0d", sample, exp); errors++; end
    checks++; if (overrun !== 1'b1) begin $display("FAIL ovr_set: got %b want 1", overrun); errors++; end
    sample_ready = 1'b1;
    step();
    step();
    checks++; if (sample_valid !== 1'b0) begin $display("FAIL ovr_drain: got %b want 0", sample_valid); errors++; end
    checks++; if (overrun !== 1'b1) begin $display("FAIL ovr_sticky: got %b want 1", overrun); errors++; end
    wait_load(1);
    exp = model_push(255);
    checks++; if (sample !== exp[SW-1:0]) begin $display("FAIL ovr_third_sample: got %0d want %0d", sample, exp); errors++; end
    checks++; if (overrun !== 1'b1) begin $display("FAIL ovr_still_set: got %b want 1", overrun); errors++; end
  endtask

  task automatic test_mid_reset();
    int n;
    int exp;
    mode = 1;
    sample_ready = 1'b0;
    do_reset();
    wait_locked(n);
    wait_load(1);
    exp = model_push(255);
    checks++; if (sample !== exp[SW-1:0] || sample_valid !== 1'b1) begin
      $display("FAIL mid_pre_sample: got %0d/%b want %0d/1", sample, sample_valid, exp); errors++;
    end
    repeat (100) step();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++; if (sample !== 8'd0) begin $display("FAIL mid_sample: got %0d want 0", sample); errors++; end
    checks++; if (sample_valid !== 1'b0) begin $display("FAIL mid_valid: got %b want 0", sample_valid); errors++; end
    checks++; if (overrun !== 1'b0) begin $display("FAIL mid_overrun: got %b want 0", overrun); errors++; end
    checks++; if (locked !== 1'b0) begin $display("FAIL mid_locked: got %b want 0", locked); errors++; end
    reset = 1'b0;
    h0 = 0; h1 = 0; h2 = 0;
    sample_ready = 1'b1;
    wait_locked(n);
    checks++; if (n !== FL) begin $display("FAIL mid_relock_time: got %0d cycles want %0d", n, FL); errors++; end
    checks++; if (sample_valid !== 1'b0) begin $display("FAIL mid_partial_discard: got %b want 0", sample_valid); errors++; end
    wait_load(1);
    exp = model_push(255);
    checks++; if (sample !== exp[SW-1:0] || sample_valid !== 1'b1) begin
      $display("FAIL mid_post_sample: got %0d/%b want %0d/1", sample, sample_valid, exp); errors++;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    mode = 0;
    since = 0;
    h0 = 0; h1 = 0; h2 = 0;
    reset = 1'b1;
    sample_ready = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    test_const_high();
    test_const_low();
    test_duty25();
    test_overrun();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_capture.md
PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 The block SHALL have parameter FRAME_LEN, default 256, meaning clock cycles per PWM measurement frame (legal 4..65536).
REQ-002 The block SHALL have parameter SAMPLE_W, default 8, meaning width of the recovered sample.
REQ-003 The block SHALL have port sysclk  input  1  the single clock; all logic on its rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port Pulse_In  input  1  asynchronous PWM/PDM stream, as driven by the waveform generator's Pulse output.
REQ-006 The block SHALL have port Sample  output  SAMPLE_W  recovered duty-cycle value.
REQ-007 The block SHALL have port Sample_Valid  output  1  Sample holds an unconsumed value.
REQ-008 The block SHALL have port Sample_Ready  input  1  consumer accepts Sample when high with Sample_Valid.
REQ-009 The block SHALL have port Overrun  output  1  sticky flag: an unconsumed sample was overwritten.
REQ-010 The block SHALL have port Locked  output  1  high once the first complete frame has been measured.

Function
REQ-011 Pulse_In SHALL pass through a 2-flop synchronizer; all counting uses the synchronized value (2-cycle input latency).
REQ-012 A frame counter SHALL count 0..FRAME_LEN-1 and wrap to 0, free-running from reset.
REQ-013 A high counter SHALL increment on each cycle the synchronized input is 1 and clear to 0 at frame wrap, with the wrap cycle itself counted into the closing frame.
REQ-014 At frame wrap the closing high count SHALL be scaled as count*2^SAMPLE_W/FRAME_LEN (right shift when FRAME_LEN is a power of two) and saturated to 2^SAMPLE_W-1.
REQ-015 The state machine SHALL have states SYNC and RUN: reset enters SYNC; the first frame wrap discards its count and moves to RUN; RUN is held until reset.
REQ-016 In RUN, each frame wrap SHALL load the output register on the next cycle and set Sample_Valid (1 cycle after wrap).
REQ-017 Sample_Valid SHALL clear on the cycle after Sample_Valid && Sample_Ready, unless a new sample loads in that same cycle, in which case Sample_Valid stays 1 with the new value and Overrun is not set.
REQ-018 A new sample arriving while Sample_Valid=1 and Sample_Ready=0 SHALL overwrite Sample and set Overrun, which stays set until reset.
REQ-019 Sample SHALL remain stable while Sample_Valid=1 and no new sample loads.
REQ-020 Locked SHALL be 1 exactly when the state is RUN.

Reset
REQ-021 Reset SHALL set Sample=0, Sample_Valid=0, Overrun=0, Locked=0, both counters=0, synchronizer flops=0, state=SYNC.
REQ-022 Reset asserted mid-frame SHALL discard the partial frame; no sample is produced from it.
REQ-023 Reset SHALL take priority over every other event in the same cycle.

Configuration
REQ-024 With macro PWM_CAPTURE_AVG_EN defined, Sample SHALL be the 4-tap moving average (sum>>2, truncated) of the last four scaled frame values, with history cleared to 0 on reset so the first three outputs ramp.
REQ-025 Without PWM_CAPTURE_AVG_EN, Sample SHALL be the single-frame scaled value and no history registers exist.

Structure
REQ-026 A shared package SHALL hold the state enumeration (SYNC, RUN), the default FRAME_LEN and SAMPLE_W constants, and the synchronizer depth (2).
REQ-027 The synchronizer SHALL be a separate sub-module named pulse_sync; all other logic stays in pwm_capture.

Verification
REQ-028 Bench SHALL drive Pulse_In=1 constant, Sample_Ready=1 -> first Sample_Valid one frame after Locked rises, Sample=255 every frame.
REQ-029 Bench SHALL drive Pulse_In=0 constant -> Sample=0 each frame, Locked=1 after first wrap.
REQ-030 Bench SHALL drive a 25% duty PWM (64 high / 192 low, period 256) -> Sample=64 (+/-1 for phase) every frame.
REQ-031 Bench SHALL hold Sample_Ready=0 across two frame wraps -> Sample updates to the second value, Overrun=1 and stays 1 after Ready returns.
REQ-032 Bench SHALL assert reset mid-frame at count 100 -> all outputs return to reset values next cycle; Locked=0 until one full frame elapses.
REQ-033 With PWM_CAPTURE_AVG_EN, bench SHALL drive constant 1 -> successive Sample values 63, 127, 191, 255.
